// File: rtl/byte_data_mem_pkg.sv
// Shared encodings for the byte-addressable data memory.
// Access sizes and clear-FSM states.
package byte_data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/byte_data_mem_lane_align.sv
// Lane steering for the data memory: store byte enables/replication
// and load extraction with sign/zero extension.
module mem_lane_align
  import byte_data_mem_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wsh_o,
  output logic [31:0] rd_o
);

  logic        is_b;
  logic        is_h;
  logic [31:0] sh_word;
  logic [7:0]  b;
  logic [15:0] h;

  assign is_b    = (size_i == SZ_BYTE);
  assign is_h    = (size_i == SZ_HALF);
  assign sh_word = word_i >> {lane_i, 3'b000};
  assign b       = sh_word[7:0];
  assign h       = lane_i[1] ? word_i[31:16] : word_i[15:0];

  // Store: pick lanes and replicate data across them
  always_comb begin
    be_o  = 4'b1111;
    wsh_o = wd_i;
    unique case (1'b1)
      is_b: begin
        be_o  = 4'b0001 << lane_i;
        wsh_o = {4{wd_i[7:0]}};
      end
      is_h: begin
        be_o  = lane_i[1] ? 4'b1100 : 4'b0011;
        wsh_o = {2{wd_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load: extract the lane and extend to 32 bits
  always_comb begin
    rd_o = word_i;
    unique case (1'b1)
      is_b: rd_o = {{24{b[7] & ~uns_i}}, b};
      is_h: rd_o = {{16{h[15] & ~uns_i}}, h};
      default: ;
    endcase
  end

endmodule

// File: rtl/byte_data_mem.sv
// Byte-addressable data memory with SB/SH/SW, LB/LBU/LH/LHU/LW,
// error flagging and a self-clearing sweep after reset.
module byte_data_mem
  import byte_data_mem_pkg::*;
#(
  parameter int ADD_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int TEST_WORD  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADD_WIDTH-1:0]  A,
  input  logic                  WE,
  input  logic                  RE,
  input  logic [1:0]            SIZE,
  input  logic                  UNS,
  input  logic [DATA_WIDTH-1:0] WD,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  busy,
  output logic                  err,
  output logic [15:0]           test_value
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] CNT_MAX = '1;
  localparam logic [DEPTH_LOG2-1:0] TW =
    TEST_WORD[DEPTH_LOG2-1:0];

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  state_e                state_q;
  state_e                state_d;
  logic [DEPTH_LOG2-1:0] cnt_q;
  logic [DEPTH_LOG2-1:0] cnt_d;

  logic [DEPTH_LOG2-1:0] idx;
  logic                  is_h;
  logic                  is_w;
  logic                  oor;
  logic                  mis;
  logic                  st_ok;
  logic [3:0]            be;
  logic [31:0]           wsh;
  logic [31:0]           rd_ext;

  assign idx  = A[DEPTH_LOG2+1:2];
  assign is_h = (SIZE == SZ_HALF);
  assign is_w = SIZE[1];
  assign oor  = |(A >> (DEPTH_LOG2 + 2));
  assign mis  = (is_h & A[0]) | (is_w & (|A[1:0]));
  assign busy = (state_q == CLEAR);
  assign err  = ~busy & (WE | RE) & (oor | mis);
  assign st_ok = ~busy & WE & ~oor & ~mis;

  mem_lane_align u_align (
    .lane_i (A[1:0]),
    .size_i (SIZE),
    .uns_i  (UNS),
    .wd_i   (WD),
    .word_i (mem_q[idx]),
    .be_o   (be),
    .wsh_o  (wsh),
    .rd_o   (rd_ext)
  );

  assign RD = (busy | oor | mis) ? '0 : rd_ext;
  assign test_value = busy ? 16'h0 : mem_q[TW][15:0];

  // Clear FSM state and sweep counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep every word once, then park in READY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_MAX) state_d = READY;
      end
      READY: ;
      default: state_d = CLEAR;
    endcase
  end

  // Array write: sweep zeroes while clearing, lane stores when ready
  always_ff @(posedge clk) begin
    if (busy && !rst) begin
      mem_q[cnt_q] <= '0;
    end else if (st_ok && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][i*8 +: 8] <= wsh[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_byte_data_mem.sv
// Directed self-checking bench for byte_data_mem.
// Hand-computed expectations for stores, loads, errors, clear sweep.
module tb_byte_data_mem;
  import byte_data_mem_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic        WE;
  logic        RE;
  logic [1:0]  SIZE;
  logic        UNS;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        busy;
  logic        err;
  logic [15:0] test_value;

  int checks = 0;
  int errors = 0;
  int n;
  logic [31:0] r;

  byte_data_mem dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .WE         (WE),
    .RE         (RE),
    .SIZE       (SIZE),
    .UNS        (UNS),
    .WD         (WD),
    .RD         (RD),
    .busy       (busy),
    .err        (err),
    .test_value (test_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic st(input logic [31:0] a,
                    input logic [1:0] sz,
                    input logic [31:0] d);
    A = a; SIZE = sz; WD = d; WE = 1'b1; RE = 1'b0;
    @(posedge clk); #1;
    WE = 1'b0;
  endtask

  task automatic st_err(input string tag,
                        input logic [31:0] a,
                        input logic [1:0] sz,
                        input logic [31:0] d);
    A = a; SIZE = sz; WD = d; WE = 1'b1; RE = 1'b0;
    #1;
    chk(tag, {31'd0, err}, 32'd1);
    @(posedge clk); #1;
    WE = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a,
                    input logic [1:0] sz,
                    input logic u,
                    output logic [31:0] d);
    A = a; SIZE = sz; UNS = u; RE = 1'b1; WE = 1'b0;
    #1;
    d = RD;
    RE = 1'b0;
  endtask

  task automatic count_busy(input int drop_at,
                            output int cnt);
    cnt = 0;
    while (busy && cnt < 5000) begin
      if (cnt == drop_at) begin
        A = 32'h0; SIZE = SZ_WORD;
        WD = 32'h1234_5678; WE = 1'b1;
        #1;
        chk("err_busy", {31'd0, err}, 32'd0);
      end
      @(posedge clk); #1;
      WE = 1'b0;
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; A = '0; WE = 1'b1; RE = 1'b1;
    SIZE = SZ_WORD; UNS = 1'b0; WD = 32'hFFFF_FFFF;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_rd", RD, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_tv", {16'd0, test_value}, 32'd0);
    @(posedge clk); #1;
    WE = 1'b0; RE = 1'b0;
    rst = 1'b0;

    count_busy(-1, n);
    chk("clr_cycles", n, 32'd1024);

    for (int w = 0; w < 1024; w += 64) begin
      ld(w * 4, SZ_WORD, 1'b0, r);
      chk($sformatf("clr_w%0d", w), r, 32'd0);
    end

    st(32'h10, SZ_WORD, 32'h8899_AABB);
    st(32'h11, SZ_BYTE, 32'h0000_0011);
    ld(32'h10, SZ_WORD, 1'b0, r);
    chk("lw_10", r, 32'h8899_11BB);
    ld(32'h13, SZ_BYTE, 1'b0, r);
    chk("lb_13", r, 32'hFFFF_FF88);
    ld(32'h13, SZ_BYTE, 1'b1, r);
    chk("lbu_13", r, 32'h0000_0088);
    ld(32'h10, SZ_BYTE, 1'b0, r);
    chk("lb_10", r, 32'hFFFF_FFBB);

    st(32'h22, SZ_HALF, 32'h0000_8001);
    ld(32'h22, SZ_HALF, 1'b0, r);
    chk("lh_22", r, 32'hFFFF_8001);
    ld(32'h22, SZ_HALF, 1'b1, r);
    chk("lhu_22", r, 32'h0000_8001);
    ld(32'h20, SZ_WORD, 1'b0, r);
    chk("lw_20", r, 32'h8001_0000);
    ld(32'h20, SZ_HALF, 1'b0, r);
    chk("lh_20", r, 32'h0000_0000);

    st(32'h04, SZ_WORD, 32'h1234_5678);
    st_err("err_mis_sw", 32'h06, SZ_WORD, 32'hDEAD_BEEF);
    st_err("err_oor_sw", 32'h1000, SZ_WORD, 32'hDEAD_BEEF);
    st_err("err_mis_sh", 32'h05, SZ_HALF, 32'hDEAD_BEEF);
    ld(32'h04, SZ_WORD, 1'b0, r);
    chk("lw_04", r, 32'h1234_5678);
    A = 32'h1000; SIZE = SZ_WORD; RE = 1'b1; #1;
    chk("oor_rd", RD, 32'd0);
    chk("oor_err", {31'd0, err}, 32'd1);
    RE = 1'b0; #1;
    chk("idle_err", {31'd0, err}, 32'd0);
    ld(32'h06, SZ_WORD, 1'b0, r);
    chk("mis_rd", r, 32'd0);
    ld(32'h07, SZ_BYTE, 1'b1, r);
    chk("lbu_07", r, 32'h0000_0012);

    A = 32'h30; SIZE = SZ_WORD; WD = 32'hCAFE_F00D;
    WE = 1'b1; RE = 1'b1; #1;
    chk("rmw_pre", RD, 32'd0);
    @(posedge clk); #1;
    chk("rmw_post", RD, 32'hCAFE_F00D);
    WE = 1'b0; RE = 1'b0;

    A = 32'h0; SIZE = SZ_WORD; WD = 32'h0000_BEEF;
    WE = 1'b1; #1;
    chk("tv_pre", {16'd0, test_value}, 32'd0);
    @(posedge clk); #1;
    WE = 1'b0;
    chk("tv_post", {16'd0, test_value}, 32'h0000_BEEF);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; #1;
    chk("mid_rst_tv", {16'd0, test_value}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy(10, n);
    chk("reclr_cycles", n, 32'd1024);
    ld(32'h0, SZ_WORD, 1'b0, r);
    chk("drop_lw0", r, 32'd0);
    chk("drop_tv", {16'd0, test_value}, 32'd0);
    ld(32'h10, SZ_WORD, 1'b0, r);
    chk("reclr_lw10", r, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
